key_schedule_ctrl: RTL

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

---
 rtl/aes_pkg.sv | 24 ++
 rtl/key_schedule_ctrl_rcon_gen.sv | 22 ++
 rtl/key_schedule_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, controller state encoding and the
// GF(2^8) doubling helper used to step the round constant.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;
  localparam int WORD_W     = 32;

  localparam logic [7:0] RC_FIRST = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_rcon_gen.sv
// Round-constant generator: init seeds 01, each step doubles it in GF(2^8).
module rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       step,
  output logic [7:0] rc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rc <= RC_FIRST;
    end else if (init) begin
      rc <= RC_FIRST;
    end else if (step) begin
      rc <= xtime(rc);
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequences an external AES-128 key-expansion stage and captures the eleven
// round keys into a buffer with a registered, one-cycle-latency read port.
module key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  output logic              ke_load_enable,
  output logic [KEY_W-1:0]  ke_key_in,
  output logic [WORD_W-1:0] ke_rcon,
  input  logic [KEY_W-1:0]  ke_key_out,
  input  logic [3:0]        rk_rd_addr,
  output logic [KEY_W-1:0]  rk_rd_data,
  output logic              busy,
  output logic              done,
  output logic              rk_valid
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t            state;
  logic [3:0]        r;
  logic [7:0]        rc;
  logic              rc_init;
  logic              rc_step;
  logic [WORD_W-1:0] rc_word;
  logic              wr_en;
  logic [3:0]        wr_idx;
  logic [KEY_W-1:0]  rk_buf [0:NUM_ROUNDS];

  // rc runs one round ahead of ke_rcon so the registered output sees rc(r) on entry to round r.
  assign rc_init = (state == ST_IDLE) && start;
  assign rc_step = (state == ST_LOAD) || ((state == ST_EXPAND) && (r != LAST_ROUND));
  assign rc_word = {rc, {(WORD_W-8){1'b0}}};

  rcon_gen u_rcon_gen (
    .clk  (clk),
    .rst  (rst),
    .init (rc_init),
    .step (rc_step),
    .rc   (rc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      r              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rk_valid       <= 1'b0;
      ke_load_enable <= 1'b0;
      ke_rcon        <= '0;
      ke_key_in      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ke_key_in      <= key_in;
            rk_valid       <= 1'b0;
            busy           <= 1'b1;
            ke_load_enable <= 1'b1;
            ke_rcon        <= '0;
            state          <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          ke_load_enable <= 1'b0;
          ke_rcon        <= rc_word;
          r              <= 4'd1;
          state          <= ST_EXPAND;
        end
        ST_EXPAND: begin
          if (r == LAST_ROUND) begin
            ke_rcon <= '0;
            state   <= ST_CAPTURE;
          end else begin
            ke_rcon <= rc_word;
            r       <= r + 4'd1;
          end
        end
        ST_CAPTURE: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          rk_valid <= 1'b1;
          r        <= '0;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy           <= 1'b0;
          done           <= 1'b0;
          ke_load_enable <= 1'b0;
          ke_rcon        <= '0;
          r              <= '0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    if (state == ST_EXPAND) begin
      wr_en  = 1'b1;
      wr_idx = r - 4'd1;
    end else if (state == ST_CAPTURE) begin
      wr_en  = 1'b1;
      wr_idx = LAST_ROUND;
    end
  end

  // Buffer storage deliberately has no reset; rk_valid qualifies its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rk_buf[wr_idx] <= ke_key_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_rd_data <= '0;
    end else if (rk_rd_addr <= LAST_ROUND) begin
      rk_rd_data <= rk_buf[rk_rd_addr];
    end else begin
      rk_rd_data <= '0;
    end
  end

endmodule
